mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Three-way memory port arbiter: per-requester input FIFOs, round-robin issue
// onto a single request port, and an in-order tag FIFO that steers each
// in-order memory response back to the requester that issued it.
module mem_port_arbiter #(
  parameter int unsigned IN_DEPTH    = 16,
  parameter int unsigned AFULL_SLACK = 4,
  parameter int unsigned TAG_DEPTH   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_0_vld_in,
  input  logic [47:0] req_0_address_in,
  output logic        req_0_afull_out,
  input  logic        req_1_vld_in,
  input  logic [47:0] req_1_address_in,
  output logic        req_1_afull_out,
  input  logic        req_2_vld_in,
  input  logic [47:0] req_2_address_in,
  output logic        req_2_afull_out,
  input  logic        rsp_0_afull_in,
  output logic        rsp_0_write_en_out,
  output logic [63:0] rsp_0_data_out,
  input  logic        rsp_1_afull_in,
  output logic        rsp_1_write_en_out,
  output logic [63:0] rsp_1_data_out,
  input  logic        rsp_2_afull_in,
  output logic        rsp_2_write_en_out,
  output logic [63:0] rsp_2_data_out,
  input  logic        mem_rq_afull_in,
  output logic        mem_rq_vld_out,
  output logic [47:0] mem_rq_address_out,
  output logic        mem_rs_afull_out,
  input  logic        mem_rs_write_en_in,
  input  logic [63:0] mem_rs_data_in,
  output logic        idle_out,
  output logic        err_out
);

  localparam int unsigned NREQ      = 3;
  localparam int unsigned ID_W      = 2;
  localparam int unsigned AW        = 48;
  localparam int unsigned DW        = 64;
  localparam int unsigned IN_PW     = $clog2(IN_DEPTH);
  localparam int unsigned IN_CW     = IN_PW + 1;
  localparam int unsigned TAG_PW    = $clog2(TAG_DEPTH);
  localparam int unsigned TAG_CW    = TAG_PW + 1;
  localparam int unsigned AFULL_LVL = IN_DEPTH - AFULL_SLACK;

  // Requester-indexed views of the flat ports
  logic [NREQ-1:0] push_vld;
  logic [AW-1:0]   push_addr [NREQ];
  logic [NREQ-1:0] rsp_afull;

  assign push_vld     = {req_2_vld_in, req_1_vld_in, req_0_vld_in};
  assign push_addr[0] = req_0_address_in;
  assign push_addr[1] = req_1_address_in;
  assign push_addr[2] = req_2_address_in;
  assign rsp_afull    = {rsp_2_afull_in, rsp_1_afull_in, rsp_0_afull_in};

  // Input FIFO state
  logic [AW-1:0]    in_mem     [NREQ][IN_DEPTH];
  logic [IN_PW-1:0] in_wr_ptr  [NREQ];
  logic [IN_PW-1:0] in_rd_ptr  [NREQ];
  logic [IN_CW-1:0] in_cnt     [NREQ];
  logic [IN_CW-1:0] in_cnt_nxt [NREQ];
  logic [NREQ-1:0]  in_nonempty;
  logic [NREQ-1:0]  in_full;
  logic [NREQ-1:0]  push_ok;
  logic [NREQ-1:0]  push_drop;
  logic [NREQ-1:0]  pop;
  logic [NREQ-1:0]  req_afull;
  logic             in_all_empty_nxt;

  // Arbiter state
  logic [ID_W-1:0]  last_id;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  cand;
  logic             grant_vld;
  logic             issue_ok;
  logic [AW-1:0]    pop_addr;
  logic             rq_vld;
  logic [AW-1:0]    rq_addr;

  // Tag FIFO state
  logic [ID_W-1:0]   tag_mem [TAG_DEPTH];
  logic [TAG_PW-1:0] tag_wr_ptr;
  logic [TAG_PW-1:0] tag_rd_ptr;
  logic [TAG_CW-1:0] tag_cnt;
  logic [TAG_CW-1:0] tag_cnt_nxt;
  logic [ID_W-1:0]   tag_head;
  logic              tag_pop;
  logic              rs_orphan;

  // Response and status registers
  logic [NREQ-1:0] rsp_we;
  logic [DW-1:0]   rsp_data [NREQ];
  logic            err;
  logic            rs_afull;
  logic            idle;

  // Input FIFO occupancy flags and push acceptance
  always_comb begin
    for (int unsigned r = 0; r < NREQ; r++) begin
      in_nonempty[r] = (in_cnt[r] != '0);
      in_full[r]     = (in_cnt[r] == IN_CW'(IN_DEPTH));
      push_ok[r]     = push_vld[r] && !in_full[r];
      push_drop[r]   = push_vld[r] && in_full[r];
    end
  end

  // Round-robin pick: first non-empty requester after the last one granted
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    issue_ok  = !mem_rq_afull_in && (tag_cnt < TAG_CW'(TAG_DEPTH));
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = ID_W'((32'(last_id) + k) % NREQ);
      if (issue_ok && !grant_vld && in_nonempty[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign pop_addr = in_mem[grant_id][in_rd_ptr[grant_id]];

  // Pops and next-cycle occupancy of the input FIFOs
  always_comb begin
    in_all_empty_nxt = 1'b1;
    for (int unsigned r = 0; r < NREQ; r++) begin
      pop[r]        = grant_vld && (grant_id == ID_W'(r));
      in_cnt_nxt[r] = in_cnt[r] + IN_CW'(push_ok[r]) - IN_CW'(pop[r]);
      if (in_cnt_nxt[r] != '0) begin
        in_all_empty_nxt = 1'b0;
      end
    end
  end

  // Input FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (push_ok[r]) begin
        in_mem[r][in_wr_ptr[r]] <= push_addr[r];
      end
    end
  end

  // Input FIFO pointers, counts and almost-full flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREQ; r++) begin
        in_wr_ptr[r] <= '0;
        in_rd_ptr[r] <= '0;
        in_cnt[r]    <= '0;
      end
      req_afull <= '0;
    end else begin
      for (int unsigned r = 0; r < NREQ; r++) begin
        if (push_ok[r]) begin
          in_wr_ptr[r] <= in_wr_ptr[r] + IN_PW'(1);
        end
        if (pop[r]) begin
          in_rd_ptr[r] <= in_rd_ptr[r] + IN_PW'(1);
        end
        in_cnt[r]    <= in_cnt_nxt[r];
        req_afull[r] <= (in_cnt_nxt[r] >= IN_CW'(AFULL_LVL));
      end
    end
  end

  // Memory request register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rq_vld  <= 1'b0;
      rq_addr <= '0;
      last_id <= ID_W'(NREQ - 1);
    end else begin
      rq_vld <= grant_vld;
      if (grant_vld) begin
        rq_addr <= pop_addr;
        last_id <= grant_id;
      end
    end
  end

  assign tag_pop     = mem_rs_write_en_in && (tag_cnt != '0);
  assign rs_orphan   = mem_rs_write_en_in && (tag_cnt == '0);
  assign tag_head    = tag_mem[tag_rd_ptr];
  assign tag_cnt_nxt = tag_cnt + TAG_CW'(grant_vld) - TAG_CW'(tag_pop);

  // Tag FIFO storage: requester ID of every issued request
  always_ff @(posedge clk) begin
    if (grant_vld) begin
      tag_mem[tag_wr_ptr] <= grant_id;
    end
  end

  // Tag FIFO pointers and outstanding count
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_cnt    <= '0;
    end else begin
      if (grant_vld) begin
        tag_wr_ptr <= tag_wr_ptr + TAG_PW'(1);
      end
      if (tag_pop) begin
        tag_rd_ptr <= tag_rd_ptr + TAG_PW'(1);
      end
      tag_cnt <= tag_cnt_nxt;
    end
  end

  // Steer each response to the requester at the head of the tag FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_we <= '0;
      for (int unsigned r = 0; r < NREQ; r++) begin
        rsp_data[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREQ; r++) begin
        rsp_we[r] <= tag_pop && (tag_head == ID_W'(r));
        if (tag_pop && (tag_head == ID_W'(r))) begin
          rsp_data[r] <= mem_rs_data_in;
        end
      end
    end
  end

  // Sticky error, response throttle and idle indication
  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      rs_afull <= 1'b0;
      idle     <= 1'b1;
    end else begin
      err      <= err | (|push_drop) | rs_orphan;
      rs_afull <= |rsp_afull;
      idle     <= in_all_empty_nxt && (tag_cnt_nxt == '0) && !tag_pop;
    end
  end

  assign req_0_afull_out    = req_afull[0];
  assign req_1_afull_out    = req_afull[1];
  assign req_2_afull_out    = req_afull[2];
  assign rsp_0_write_en_out = rsp_we[0];
  assign rsp_1_write_en_out = rsp_we[1];
  assign rsp_2_write_en_out = rsp_we[2];
  assign rsp_0_data_out     = rsp_data[0];
  assign rsp_1_data_out     = rsp_data[1];
  assign rsp_2_data_out     = rsp_data[2];
  assign mem_rq_vld_out     = rq_vld;
  assign mem_rq_address_out = rq_addr;
  assign mem_rs_afull_out   = rs_afull;
  assign idle_out           = idle;
  assign err_out            = err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: constant vector table, directed multi-cycle
// sequences and random traffic, all checked against a queue-based model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  vld;
  logic [47:0] addr [3];
  logic [2:0]  rsp_af;
  logic        rq_afull;
  logic        rs_we;
  logic [63:0] rs_data;

  logic        req_0_afull_out, req_1_afull_out, req_2_afull_out;
  logic        rsp_0_write_en_out, rsp_1_write_en_out, rsp_2_write_en_out;
  logic [63:0] rsp_0_data_out, rsp_1_data_out, rsp_2_data_out;
  logic        mem_rq_vld_out;
  logic [47:0] mem_rq_address_out;
  logic        mem_rs_afull_out;
  logic        idle_out;
  logic        err_out;

  mem_port_arbiter dut (
    .clk                (clk),
    .rst                (rst),
    .req_0_vld_in       (vld[0]),
    .req_0_address_in   (addr[0]),
    .req_0_afull_out    (req_0_afull_out),
    .req_1_vld_in       (vld[1]),
    .req_1_address_in   (addr[1]),
    .req_1_afull_out    (req_1_afull_out),
    .req_2_vld_in       (vld[2]),
    .req_2_address_in   (addr[2]),
    .req_2_afull_out    (req_2_afull_out),
    .rsp_0_afull_in     (rsp_af[0]),
    .rsp_0_write_en_out (rsp_0_write_en_out),
    .rsp_0_data_out     (rsp_0_data_out),
    .rsp_1_afull_in     (rsp_af[1]),
    .rsp_1_write_en_out (rsp_1_write_en_out),
    .rsp_1_data_out     (rsp_1_data_out),
    .rsp_2_afull_in     (rsp_af[2]),
    .rsp_2_write_en_out (rsp_2_write_en_out),
    .rsp_2_data_out     (rsp_2_data_out),
    .mem_rq_afull_in    (rq_afull),
    .mem_rq_vld_out     (mem_rq_vld_out),
    .mem_rq_address_out (mem_rq_address_out),
    .mem_rs_afull_out   (mem_rs_afull_out),
    .mem_rs_write_en_in (rs_we),
    .mem_rs_data_in     (rs_data),
    .idle_out           (idle_out),
    .err_out            (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending requests as one ordered list, outstanding tags as a queue
  typedef struct {
    int          id;
    logic [47:0] addr;
  } pend_t;

  pend_t       pend[$];
  int          mtag[$];
  int          mlast = 2;
  bit          merr  = 1'b0;
  bit          e_rq_vld;
  logic [47:0] e_rq_addr;
  bit   [2:0]  e_rsp_we;
  logic [63:0] e_rsp_data [3];
  bit   [2:0]  e_afull;
  bit          e_idle = 1'b1;
  bit          e_rs_afull;
  logic [47:0] issued[$];

  function automatic int count_id(int r);
    int n = 0;
    foreach (pend[i]) if (pend[i].id == r) n++;
    return n;
  endfunction

  task automatic model_step();
    int sz [3];
    int g;
    int c;
    int idx;
    int id;
    if (rst) begin
      pend.delete();
      mtag.delete();
      mlast      = 2;
      merr       = 1'b0;
      e_rq_vld   = 1'b0;
      e_rq_addr  = '0;
      e_rsp_we   = '0;
      for (int r = 0; r < 3; r++) e_rsp_data[r] = '0;
      e_afull    = '0;
      e_idle     = 1'b1;
      e_rs_afull = 1'b0;
      return;
    end
    for (int r = 0; r < 3; r++) sz[r] = count_id(r);
    g = -1;
    if (!rq_afull && mtag.size() < 64) begin
      for (int k = 1; k <= 3; k++) begin
        c = (mlast + k) % 3;
        if (g < 0 && sz[c] > 0) g = c;
      end
    end
    e_rsp_we = '0;
    if (rs_we) begin
      if (mtag.size() == 0) merr = 1'b1;
      else begin
        id = mtag.pop_front();
        e_rsp_we[id]   = 1'b1;
        e_rsp_data[id] = rs_data;
      end
    end
    e_rq_vld = (g >= 0);
    if (g >= 0) begin
      idx = -1;
      foreach (pend[i]) if (idx < 0 && pend[i].id == g) idx = i;
      e_rq_addr = pend[idx].addr;
      pend.delete(idx);
      mtag.push_back(g);
      mlast = g;
    end
    for (int r = 0; r < 3; r++) begin
      if (vld[r]) begin
        if (sz[r] >= 16) merr = 1'b1;
        else pend.push_back('{id: r, addr: addr[r]});
      end
    end
    for (int r = 0; r < 3; r++) e_afull[r] = (count_id(r) >= 12);
    e_idle     = (pend.size() == 0) && (mtag.size() == 0) && (e_rsp_we == 3'b000);
    e_rs_afull = |rsp_af;
  endtask

  // One clock: advance the model, clock the DUT, compare every output
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    if (mem_rq_vld_out) issued.push_back(mem_rq_address_out);
    check("rq_vld", 64'(mem_rq_vld_out), 64'(e_rq_vld));
    if (e_rq_vld) check("rq_addr", 64'(mem_rq_address_out), 64'(e_rq_addr));
    check("rsp_we", 64'({rsp_2_write_en_out, rsp_1_write_en_out, rsp_0_write_en_out}), 64'(e_rsp_we));
    if (e_rsp_we[0]) check("rsp0_data", rsp_0_data_out, e_rsp_data[0]);
    if (e_rsp_we[1]) check("rsp1_data", rsp_1_data_out, e_rsp_data[1]);
    if (e_rsp_we[2]) check("rsp2_data", rsp_2_data_out, e_rsp_data[2]);
    check("req_afull", 64'({req_2_afull_out, req_1_afull_out, req_0_afull_out}), 64'(e_afull));
    check("idle", 64'(idle_out), 64'(e_idle));
    check("err", 64'(err_out), 64'(merr));
    check("rs_afull", 64'(mem_rs_afull_out), 64'(e_rs_afull));
    rst   = 1'b0;
    vld   = '0;
    rs_we = 1'b0;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((pend.size() > 0 || mtag.size() > 0 || !e_idle) && n < budget) begin
      rs_we   = (mtag.size() > 0) && ($urandom % 4 != 0);
      rs_data = {$urandom, $urandom};
      step();
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: still busy after %0d cycles", n);
    end
  endtask

  typedef struct {
    bit          rst;
    bit   [2:0]  vld;
    logic [47:0] a;
    bit          rs_we;
    logic [63:0] d;
    bit          rq_vld;
    logic [47:0] rq_addr;
    bit   [2:0]  rsp_we;
    logic [63:0] rsp_d;
    bit          idle;
    bit          err;
  } vec_t;

  localparam int NV = 9;
  vec_t tbl [NV];

  initial begin
    int pushed;
    int cyc;
    int n0;
    logic [47:0] ea;

    rst = 1'b1; vld = '0; rsp_af = '0; rq_afull = 1'b0; rs_we = 1'b0; rs_data = '0;
    for (int r = 0; r < 3; r++) addr[r] = '0;

    // Single request, response routing, orphan response, reset clears err
    tbl[0] = '{rst:1, vld:3'b000, a:48'h0,    rs_we:0, d:64'h0,  rq_vld:0, rq_addr:48'h0,    rsp_we:3'b000, rsp_d:64'h0,  idle:1, err:0};
    tbl[1] = '{rst:0, vld:3'b010, a:48'h1000, rs_we:0, d:64'h0,  rq_vld:0, rq_addr:48'h0,    rsp_we:3'b000, rsp_d:64'h0,  idle:0, err:0};
    tbl[2] = '{rst:0, vld:3'b000, a:48'h0,    rs_we:0, d:64'h0,  rq_vld:1, rq_addr:48'h1000, rsp_we:3'b000, rsp_d:64'h0,  idle:0, err:0};
    tbl[3] = '{rst:0, vld:3'b000, a:48'h0,    rs_we:0, d:64'h0,  rq_vld:0, rq_addr:48'h0,    rsp_we:3'b000, rsp_d:64'h0,  idle:0, err:0};
    tbl[4] = '{rst:0, vld:3'b000, a:48'h0,    rs_we:1, d:64'hAB, rq_vld:0, rq_addr:48'h0,    rsp_we:3'b010, rsp_d:64'hAB, idle:0, err:0};
    tbl[5] = '{rst:0, vld:3'b000, a:48'h0,    rs_we:0, d:64'h0,  rq_vld:0, rq_addr:48'h0,    rsp_we:3'b000, rsp_d:64'h0,  idle:1, err:0};
    tbl[6] = '{rst:0, vld:3'b000, a:48'h0,    rs_we:1, d:64'h55, rq_vld:0, rq_addr:48'h0,    rsp_we:3'b000, rsp_d:64'h0,  idle:1, err:1};
    tbl[7] = '{rst:0, vld:3'b000, a:48'h0,    rs_we:0, d:64'h0,  rq_vld:0, rq_addr:48'h0,    rsp_we:3'b000, rsp_d:64'h0,  idle:1, err:1};
    tbl[8] = '{rst:1, vld:3'b000, a:48'h0,    rs_we:0, d:64'h0,  rq_vld:0, rq_addr:48'h0,    rsp_we:3'b000, rsp_d:64'h0,  idle:1, err:0};

    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].rst;
      vld = tbl[i].vld;
      for (int r = 0; r < 3; r++) addr[r] = tbl[i].a;
      rs_we   = tbl[i].rs_we;
      rs_data = tbl[i].d;
      step();
      check($sformatf("vec%0d_rq_vld", i), 64'(mem_rq_vld_out), 64'(tbl[i].rq_vld));
      if (tbl[i].rq_vld || tbl[i].rst)
        check($sformatf("vec%0d_rq_addr", i), 64'(mem_rq_address_out), 64'(tbl[i].rq_addr));
      check($sformatf("vec%0d_rsp_we", i),
            64'({rsp_2_write_en_out, rsp_1_write_en_out, rsp_0_write_en_out}), 64'(tbl[i].rsp_we));
      if (tbl[i].rsp_we[0] || tbl[i].rst) check($sformatf("vec%0d_rsp0_d", i), rsp_0_data_out, tbl[i].rsp_d);
      if (tbl[i].rsp_we[1] || tbl[i].rst) check($sformatf("vec%0d_rsp1_d", i), rsp_1_data_out, tbl[i].rsp_d);
      if (tbl[i].rsp_we[2] || tbl[i].rst) check($sformatf("vec%0d_rsp2_d", i), rsp_2_data_out, tbl[i].rsp_d);
      check($sformatf("vec%0d_idle", i), 64'(idle_out), 64'(tbl[i].idle));
      check($sformatf("vec%0d_err", i), 64'(err_out), 64'(tbl[i].err));
    end

    // Fairness: all requesters push 4 each in the same cycles
    issued.delete();
    for (int i = 0; i < 4; i++) begin
      vld = 3'b111;
      for (int r = 0; r < 3; r++) addr[r] = 48'h100000 + 48'(r * 16 + i);
      step();
    end
    cyc = 0;
    while (issued.size() < 12 && cyc < 40) begin step(); cyc++; end
    check("fair_count", 64'(issued.size()), 64'd12);
    for (int k = 0; k < 12 && k < issued.size(); k++) begin
      ea = 48'h100000 + 48'((k % 3) * 16 + k / 3);
      check($sformatf("fair_order%0d", k), 64'(issued[k]), 64'(ea));
    end
    for (int k = 0; k < 12; k++) begin
      rs_we   = 1'b1;
      rs_data = 64'(48'h100000 + 48'((k % 3) * 16 + k / 3));
      step();
    end
    drain(50);

    // Backpressure: port almost full, 12 pushes to requester 0
    issued.delete();
    rq_afull = 1'b1;
    for (int i = 0; i < 12; i++) begin
      vld     = 3'b001;
      addr[0] = 48'h2000 + 48'(i);
      step();
      if (i == 10) check("bp_afull_11", 64'(req_0_afull_out), 64'd0);
      if (i == 11) check("bp_afull_12", 64'(req_0_afull_out), 64'd1);
    end
    step();
    check("bp_no_issue", 64'(issued.size()), 64'd0);
    rq_afull = 1'b0;
    drain(100);
    check("bp_issued_all", 64'(issued.size()), 64'd12);
    check("bp_err", 64'(err_out), 64'd0);

    // Tag limit: 70 requests, no responses
    issued.delete();
    pushed = 0;
    cyc    = 0;
    while (!(pushed == 70 && mtag.size() == 64) && cyc < 400) begin
      if (pushed < 70 && count_id(cyc % 3) < 14) begin
        vld[cyc % 3]  = 1'b1;
        addr[cyc % 3] = 48'h4000 + 48'(pushed);
        pushed++;
      end
      step();
      cyc++;
    end
    if (cyc >= 400) begin
      total++; bad++;
      $display("FAIL tag_fill_timeout: pushed=%0d after %0d cycles", pushed, cyc);
    end
    n0 = issued.size();
    repeat (5) step();
    check("tag_limit_count", 64'(n0), 64'd64);
    check("tag_limit_stall", 64'(issued.size()), 64'(n0));
    rs_we   = 1'b1;
    rs_data = 64'hFEED;
    step();
    repeat (4) step();
    check("tag_limit_one_more", 64'(issued.size()), 64'(n0 + 1));
    drain(300);

    // Reset with requests outstanding
    vld = 3'b111;
    for (int r = 0; r < 3; r++) addr[r] = 48'h5000 + 48'(r);
    step();
    vld = 3'b011;
    for (int r = 0; r < 3; r++) addr[r] = 48'h5010 + 48'(r);
    rsp_af = 3'b100;
    step();
    cyc = 0;
    while (mtag.size() < 5 && cyc < 20) begin step(); cyc++; end
    check("rmf_busy", 64'(idle_out), 64'd0);
    check("rmf_rs_afull_set", 64'(mem_rs_afull_out), 64'd1);
    rst = 1'b1;
    step();
    rsp_af = 3'b000;
    check("rmf_rq_vld", 64'(mem_rq_vld_out), 64'd0);
    check("rmf_rq_addr", 64'(mem_rq_address_out), 64'd0);
    check("rmf_rsp_we", 64'({rsp_2_write_en_out, rsp_1_write_en_out, rsp_0_write_en_out}), 64'd0);
    check("rmf_afull", 64'({req_2_afull_out, req_1_afull_out, req_0_afull_out}), 64'd0);
    check("rmf_rs_afull", 64'(mem_rs_afull_out), 64'd0);
    check("rmf_idle", 64'(idle_out), 64'd1);
    check("rmf_err", 64'(err_out), 64'd0);
    issued.delete();
    vld     = 3'b100;
    addr[2] = 48'h3000;
    step();
    repeat (2) step();
    check("fresh_count", 64'(issued.size()), 64'd1);
    if (issued.size() > 0) check("fresh_addr", 64'(issued[0]), 64'h3000);
    rs_we   = 1'b1;
    rs_data = 64'hCD;
    step();
    check("fresh_rsp_we", 64'(rsp_2_write_en_out), 64'd1);
    check("fresh_rsp_data", rsp_2_data_out, 64'hCD);
    step();
    check("fresh_idle", 64'(idle_out), 64'd1);

    // Orphan response: sticky error until reset
    rs_we   = 1'b1;
    rs_data = 64'h77;
    step();
    check("orphan_no_rsp", 64'({rsp_2_write_en_out, rsp_1_write_en_out, rsp_0_write_en_out}), 64'd0);
    check("orphan_err", 64'(err_out), 64'd1);
    repeat (3) step();
    check("orphan_err_sticky", 64'(err_out), 64'd1);
    rst = 1'b1;
    step();
    check("orphan_err_cleared", 64'(err_out), 64'd0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < 3; r++) begin
        vld[r]  = ($urandom % 3 == 0);
        addr[r] = 48'({$urandom, $urandom});
      end
      rq_afull = ($urandom % 5 == 0);
      rs_we    = (mtag.size() > 0) ? ($urandom % 2 == 0) : ($urandom % 64 == 0);
      rs_data  = {$urandom, $urandom};
      if ($urandom % 8 == 0) rsp_af = 3'($urandom);
      rst = ($urandom % 700 == 0);
      step();
    end
    rq_afull = 1'b0;
    rsp_af   = 3'b000;
    drain(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
